// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single asynchronous-read memory.
// Round-robin on ties; each transaction holds the memory for LATENCY cycles plus one ack cycle.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // state | meaning
  // IDLE  | no transaction; may accept one request
  // BUSY  | memory access in progress, cnt counts down to 0
  // RESP  | one-cycle ack to the granted port, then back to IDLE
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        last_grant, last_grant_nxt;
  logic        gnt, gnt_nxt;
  logic        we_q, we_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        sel_data;
  logic        access_end;

  // Data wins when it is the only requester, or on a tie when fetch was served last.
  assign sel_data   = d_req && (!if_req || !last_grant);
  assign access_end = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    we_nxt         = we_q;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt      = BUSY;
          cnt_nxt        = 4'(LATENCY - 1);
          gnt_nxt        = sel_data;
          last_grant_nxt = sel_data;
          we_nxt         = sel_data && d_we;
          addr_nxt       = sel_data ? d_addr : if_addr;
          wdata_nxt      = sel_data ? d_wdata : 32'd0;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      we_q       <= we_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      if (access_end && !we_q) begin
        if (gnt) d_rdata  <= mem_rdata;
        else     if_rdata <= mem_rdata;
      end
    end
  end

  // Write strobe is gated by rst_n so a reset in the last access cycle drops the store.
  assign mem_we    = access_end && we_q && rst_n;
  assign mem_addr  = (state == IDLE) ? 32'd0 : (addr_q & ~32'h3);
  assign mem_wdata = (state == IDLE) ? 32'd0 : wdata_q;
  assign busy      = (state != IDLE);
  assign if_ack    = (state == RESP) && !gnt;
  assign d_ack     = (state == RESP) && gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected acks,
// negedge monitors pop and compare port, cycle and read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        l1_d_req;
  logic [31:0] l1_d_addr;
  logic        l1_if_ack, l1_d_ack, l1_mem_we, l1_busy;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  mem_arbiter #(.LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'd0), .if_ack(l1_if_ack), .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(1'b0), .d_addr(l1_d_addr), .d_wdata(32'd0),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_addr(l1_mem_addr), .mem_we(l1_mem_we), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata    = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign l1_mem_rdata = {l1_mem_addr[15:0], 16'hBEEF};

  typedef struct {
    bit          port;
    int          cyc;
    logic [31:0] ifr;
    logic [31:0] dr;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  exp_t e_main, e_l1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   busy_cnt = 0;
  logic [31:0] we_addr, we_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (busy) busy_cnt++;
  end

  always @(negedge clk) begin
    if (q.size() > 0 && !(if_ack || d_ack) && cyc > q[0].cyc) begin
      tests++; fails++;
      $display("FAIL ack_missing: no ack by cycle %0d, expected at cycle %0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (if_ack || d_ack) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected: if_ack=%b d_ack=%b at cycle %0d, none expected", if_ack, d_ack, cyc);
      end else begin
        e_main = q.pop_front();
        if (if_ack !== !e_main.port || d_ack !== e_main.port || cyc != e_main.cyc ||
            if_rdata !== e_main.ifr || d_rdata !== e_main.dr) begin
          fails++;
          $display("FAIL ack_main: got if_ack=%b d_ack=%b cyc=%0d if_rdata=%h d_rdata=%h, expected port=%0d cyc=%0d if_rdata=%h d_rdata=%h",
                   if_ack, d_ack, cyc, if_rdata, d_rdata, e_main.port, e_main.cyc, e_main.ifr, e_main.dr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0 && !(l1_if_ack || l1_d_ack) && cyc > q1[0].cyc) begin
      tests++; fails++;
      $display("FAIL ack_l1_missing: no ack by cycle %0d, expected at cycle %0d", cyc, q1[0].cyc);
      void'(q1.pop_front());
    end
    if (l1_if_ack || l1_d_ack) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL ack_l1_unexpected: if_ack=%b d_ack=%b at cycle %0d", l1_if_ack, l1_d_ack, cyc);
      end else begin
        e_l1 = q1.pop_front();
        if (l1_if_ack !== !e_l1.port || l1_d_ack !== e_l1.port || cyc != e_l1.cyc ||
            l1_if_rdata !== e_l1.ifr || l1_d_rdata !== e_l1.dr) begin
          fails++;
          $display("FAIL ack_l1: got if_ack=%b d_ack=%b cyc=%0d if_rdata=%h d_rdata=%h, expected port=%0d cyc=%0d if_rdata=%h d_rdata=%h",
                   l1_if_ack, l1_d_ack, cyc, l1_if_rdata, l1_d_rdata, e_l1.port, e_l1.cyc, e_l1.ifr, e_l1.dr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int c);
    int n = 0;
    while (cyc < c && n < 200) begin
      tick();
      n++;
    end
    if (cyc < c) check("run_timeout", 32'(cyc), 32'(c));
  endtask

  task automatic push(input bit port, input int c, input logic [31:0] ifr, input logic [31:0] dr);
    exp_t e;
    e.port = port; e.cyc = c; e.ifr = ifr; e.dr = dr;
    q.push_back(e);
  endtask

  int k;
  exp_t e1;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    l1_d_req = 1'b0; l1_d_addr = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h00A00093;
    mem[2] = 32'h00000011;
    tick(); tick();

    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // fetch straight out of reset
    if_req = 1'b1; if_addr = 32'd0; busy_cnt = 0;
    k = cyc; rst_n = 1'b1;
    push(1'b0, k + 5, 32'h00A00093, 32'd0);
    run_until(k + 5);
    if_req = 1'b0;
    tick();
    check("fetch_busy_cycles", 32'(busy_cnt), 32'd5);

    // store 10 to address 100
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd100; d_wdata = 32'd10; we_cnt = 0;
    k = cyc;
    push(1'b1, k + 5, 32'h00A00093, 32'd0);
    run_until(k + 5);
    d_req = 1'b0;
    tick();
    check("store_we_count", 32'(we_cnt), 32'd1);
    check("store_we_addr", we_addr, 32'd100);
    check("store_we_data", we_data, 32'd10);
    check("store_mem_word", mem[25], 32'd10);

    // load back from address 100
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd100;
    k = cyc;
    push(1'b1, k + 5, 32'h00A00093, 32'd10);
    run_until(k + 5);
    d_req = 1'b0;
    tick();

    // load from 0; request dropped and inputs changed mid-transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd0; we_cnt = 0;
    k = cyc;
    push(1'b1, k + 5, 32'h00A00093, 32'h00A00093);
    tick(); tick();
    d_req = 1'b0; d_we = 1'b1; d_addr = 32'd100; d_wdata = 32'hDEAD_BEEF;
    run_until(k + 6);
    check("drop_no_write", 32'(we_cnt), 32'd0);
    check("drop_mem_intact", mem[25], 32'd10);
    d_we = 1'b0;

    // contention from reset, data port unaligned at 0x67
    rst_n = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h67;
    k = cyc; rst_n = 1'b1;
    push(1'b0, k + 5,  32'h00A00093, 32'd0);
    push(1'b1, k + 11, 32'h00A00093, 32'd10);
    push(1'b0, k + 17, 32'h00A00093, 32'd10);
    push(1'b1, k + 23, 32'h00A00093, 32'd10);
    run_until(k + 8);
    check("unaligned_mem_addr", mem_addr, 32'h64);
    run_until(k + 23);
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // LATENCY=1 instance: ack two edges after acceptance
    l1_d_req = 1'b1; l1_d_addr = 32'h67;
    k = cyc;
    e1.port = 1'b1; e1.cyc = k + 2; e1.ifr = 32'd0; e1.dr = 32'h0064BEEF;
    q1.push_back(e1);
    tick();
    check("l1_mem_addr", l1_mem_addr, 32'h64);
    run_until(k + 2);
    l1_d_req = 1'b0;
    tick();

    // reset during the final access cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'h55; we_cnt = 0;
    k = cyc;
    run_until(k + 4);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    check("rst_store_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    check("rst_mid_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_mid_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_if_rdata", if_rdata, 32'd0);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_mem_wdata", mem_wdata, 32'd0);
    check("rst_mid_we_count", 32'(we_cnt), 32'd0);
    check("rst_mid_mem_word", mem[2], 32'h11);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("queue_main_drained", 32'(q.size()), 32'd0);
    check("queue_l1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 4, backing-memory access cycles per transaction (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch read request; held with stable if_addr until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-007 if_rdata  output  32  fetch read data, valid when if_ack=1 and held until the next if_ack.
REQ-008 d_req  input  1  data-port request; held with stable d_we/d_addr/d_wdata until d_ack.
REQ-009 d_we  input  1  1=store, 0=load.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-013 d_rdata  output  32  load data, valid when d_ack=1 and held until the next d_ack; unchanged by stores.
REQ-014 mem_addr  output  32  word-aligned address to the shared asynchronous-read memory.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  combinational memory read data for mem_addr.
REQ-018 busy  output  1  high while a transaction is in progress (BUSY or RESP).

Function
REQ-019 The FSM SHALL have states IDLE, BUSY and RESP, plus a 4-bit down-counter cnt and a 1-bit last_grant (0=fetch, 1=data).
REQ-020 In IDLE, at an edge with any request high, the arbiter SHALL accept exactly one request, latch its port ID, address, we and wdata, load cnt=LATENCY-1 and enter BUSY.
REQ-021 Arbitration SHALL be round-robin: with a single request, grant it; with both requests high, grant the port not equal to last_grant; last_grant is updated on every acceptance.
REQ-022 In BUSY, cnt SHALL decrement each edge; at the edge where cnt==0, the arbiter SHALL enter RESP.
REQ-023 The arbiter SHALL drive mem_addr = {latched_addr[31:2], 2'b00} in BUSY and RESP, and 0 in IDLE.
REQ-024 The arbiter SHALL drive mem_wdata = latched wdata in BUSY and RESP, and 0 in IDLE.
REQ-025 mem_we SHALL be 1 only in the BUSY cycle with cnt==0 of a granted store, so exactly one write edge occurs per store.
REQ-026 At the BUSY->RESP edge of a load or fetch, mem_rdata SHALL be registered into the granted port's rdata.
REQ-027 In RESP, the granted port's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0; the state then returns to IDLE unconditionally.
REQ-028 No request SHALL be accepted at the RESP->IDLE edge; the earliest re-acceptance is the following edge.
REQ-029 Latency SHALL be LATENCY+1 edges from the acceptance edge to the edge ending the ack cycle; with LATENCY=4, ack is high in the cycle after the 4th edge following acceptance.
REQ-030 A request dropped before its ack SHALL NOT abort the transaction; the transaction completes normally and its ack is still issued.
REQ-031 A request still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-032 Changes to a granted port's inputs after acceptance SHALL have no effect on the transaction.
REQ-033 Requests arriving during BUSY or RESP SHALL wait with no loss and no ack.

Reset
REQ-034 When rst_n=0 at an edge, the block SHALL set state=IDLE, cnt=0 and last_grant=1 (the first tie therefore goes to fetch).
REQ-035 On that reset edge, if_ack, d_ack, mem_we, busy, if_rdata and d_rdata SHALL all become 0.
REQ-036 Reset SHALL take priority over every other event; a reset in BUSY aborts the transaction, issues no ack, and suppresses any pending write.

Verification
REQ-037 Fetch read: LATENCY=4, mem[0x0]=0x00A00093, if_req=1 with if_addr=0 from reset release -> if_ack is high exactly one cycle, 5 edges after acceptance; if_rdata=0x00A00093; busy is high for 5 cycles.
REQ-038 Store then load: d_we=1, d_addr=100, d_wdata=10 -> mem_we is high exactly one cycle with mem_addr=100; the following load at d_addr=100 returns d_rdata=10 with d_ack, and if_rdata is unchanged.
REQ-039 Contention: if_req and d_req held high together from reset -> grants alternate fetch, data, fetch, data, with no ack lost over 4 transactions.
REQ-040 Unaligned and latency boundaries: d_addr=0x67 -> mem_addr=0x64; with LATENCY=1, ack follows acceptance by 2 edges.
REQ-041 Reset mid-transaction: rst_n=0 during the cnt==0 cycle of a store -> no mem_write occurs, no ack is issued, and all outputs are 0 on the next cycle.
